sub_bytes_engine: RTL and testbench
===================================

# sub_bytes_engine

Parametrised, handshaked AES SubBytes/InvSubBytes engine. It accepts one 128-bit state and substitutes LANES bytes per clock through LANES S-box instances. It returns the full substituted state after 16/LANES cycles. It sits in the AES round datapath between AddRoundKey and ShiftRows, in both encrypt and decrypt round loops. It replaces the flat 16-lookup combinational substitution with an area/throughput-tunable block.

## Interface
- LANES, 16, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- NBEATS, 16/LANES, derived localparam; not overridable.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  data_in/inv are valid.
- in_ready  out  1  block can accept a state this cycle.
- data_in  in  128  input state; byte i = data_in[8*i +: 8].
- inv  in  1  1 = InvSubBytes, 0 = SubBytes; sampled with data_in.
- out_valid  out  1  data_out holds a completed result.
- out_ready  in  1  consumer takes data_out this cycle.
- data_out  out  128  substituted state; byte i = S(data_in byte i).

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: state[127:0], mode bit, beat counter of width clog2(NBEATS) (minimum 1 bit).
- IDLE: in_ready=1. On in_valid&&in_ready: capture data_in and inv, clear the counter, go to BUSY.
- BUSY: each cycle, replace bytes cnt*LANES … cnt*LANES+LANES-1 of the state register with their S-box output, then increment cnt.
  - After the beat with cnt==NBEATS-1: go to DONE.
  - in_ready=0.
  - in_valid is ignored.
- DONE: out_valid=1; data_out is the state register, held stable.
  - On out_ready: the result is consumed.
  - If in_valid is also high: accept the new state and go directly to BUSY (back-to-back).
  - Otherwise: go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready; it is permitted.
- Bytes not yet processed keep their input value in the state register. data_out is only meaningful while out_valid=1.
- Lane order runs low byte to high byte; beat 0 handles bytes 0..LANES-1.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, data_out=128'h0, cnt=0, mode=0.
- Latency: accept at edge k → out_valid high after edge k+NBEATS.
  - LANES=16: 1 cycle.
  - LANES=1: 16 cycles.
- Throughput with out_ready tied high: one state per NBEATS+1 cycles (DONE cycle overlaps the next accept).
- Backpressure: out_valid and data_out hold indefinitely in DONE until out_ready. There is no timeout.
- Reset asserted mid-BUSY or mid-DONE: the in-flight state is discarded and all outputs return to reset values asynchronously. Nothing is emitted after reset release.
- Counter never wraps; it is reloaded to 0 on every accept.

## Configuration
- SUB_BYTES_INV_EN defined: the inverse S-box table is compiled in, and inv selects forward or inverse per state.
- SUB_BYTES_INV_EN undefined: the inverse table and mode register are removed. inv is ignored and treated as 0; every state gets forward SubBytes.

## Structure
- aes_pkg holds:
  - the forward S-box and inverse S-box as constant functions or constant 256-entry arrays; no $readmemh and no absolute file paths;
  - the LANES legality check function;
  - the FSM state enum.
- Sub-module aes_sbox: 8-bit in, 8-bit out, inv input. Purely combinational; instantiated LANES times in a generate loop. Inside aes_sbox, the inverse path sits under SUB_BYTES_INV_EN.

## Test plan
- Reset → in_ready=1, out_valid=0, data_out=0. Assert rst_n low mid-BUSY → out_valid=0 immediately; no output after release.
- LANES=16, data_in=128'h0, inv=0 → out_valid 1 cycle after accept, data_out=128'h6363…63 (16 × 0x63).
- LANES=4, data_in byte i = i (128'h0f0e…0100), inv=0 → out_valid exactly 4 cycles after accept. Bytes: 0x63, 0x7c, 0x77, 0x7b, … 0x76 (byte 15).
- Inverse, SUB_BYTES_INV_EN defined, LANES=1: data_in=128'h6363…63, inv=1 → data_out=128'h0 after 16 cycles. Round-trip with 0x53→0xED→0x53.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid and data_out stable, in_ready=0. Raise out_ready with in_valid=1 → new state accepted in the same cycle; next result follows NBEATS cycles later.
- Macro undefined: inv=1 with data_in=128'h0 → data_out=128'h6363…63 (forward only).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES S-box tables, LANES legality check and the engine FSM encoding.
// The inverse table is present only when SUB_BYTES_INV_EN is defined.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sb_state_e;

    function automatic bit lanes_ok(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[b];
    endfunction

`ifdef SUB_BYTES_INV_EN
    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[b];
    endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES S-box lane; the inverse path exists only under SUB_BYTES_INV_EN.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_in,
    input  logic       i_inv,
    output logic [7:0] o_out
);

`ifdef SUB_BYTES_INV_EN
    assign o_out = i_inv ? sbox_inv(i_in) : sbox_fwd(i_in);
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
    assign o_out        = sbox_fwd(i_in);
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// Handshaked SubBytes/InvSubBytes over a 128-bit state, LANES bytes per beat.
// SUB_BYTES_INV_EN enables the inverse table and the per-state mode register.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int NBEATS = 16 / LANES;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (!lanes_ok(LANES)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e                r_fsm;
    logic [15:0][7:0]         r_data;
    logic [CW-1:0]            r_cnt;
    logic                     r_out_valid;
    logic                     w_inv;
    logic                     w_accept;
    logic [3:0]               w_base;
    logic [LANES-1:0][3:0]    w_idx;
    logic [LANES-1:0][7:0]    w_sub;

`ifdef SUB_BYTES_INV_EN
    logic r_mode;
    assign w_inv = r_mode;
`else
    logic w_unused_inv;
    assign w_unused_inv = inv;
    assign w_inv        = 1'b0;
`endif

    // out_ready feeds in_ready combinationally so DONE can overlap the next accept.
    assign in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data;
    assign w_base    = 4'(int'(r_cnt) * LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_idx[l] = w_base + 4'(l);
        aes_sbox u_sbox (
            .i_in  (r_data[w_idx[l]]),
            .i_inv (w_inv),
            .o_out (w_sub[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_data      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
`ifdef SUB_BYTES_INV_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                IDLE, DONE: begin
                    if (r_fsm == DONE && out_ready)
                        r_out_valid <= 1'b0;
                    if (w_accept) begin
                        r_data <= data_in;
                        r_cnt  <= '0;
                        r_fsm  <= BUSY;
`ifdef SUB_BYTES_INV_EN
                        r_mode <= inv;
`endif
                    end else if (r_fsm == DONE && out_ready) begin
                        r_fsm <= IDLE;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++)
                        r_data[w_idx[l]] <= w_sub[l];
                    // Counter parks on the last beat; it is reloaded on the next accept.
                    if (r_cnt == CW'(NBEATS - 1)) begin
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench: three engine instances (LANES = 16, 4, 1) sharing clock and reset.
module tb_sub_bytes_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   iv, ir, mi, ov, orr;
    logic [127:0] di   [3];
    logic [127:0] dout [3];
    int           n_chk  = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    sub_bytes_engine #(.LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .data_in(di[0]),
        .inv(mi[0]), .out_valid(ov[0]), .out_ready(orr[0]), .data_out(dout[0]));
    sub_bytes_engine #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .data_in(di[1]),
        .inv(mi[1]), .out_valid(ov[1]), .out_ready(orr[1]), .data_out(dout[1]));
    sub_bytes_engine #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .data_in(di[2]),
        .inv(mi[2]), .out_valid(ov[2]), .out_ready(orr[2]), .data_out(dout[2]));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Accept one state on instance k, measure cycles to out_valid, check result; stays in DONE.
    task automatic xact(input int k, input logic [127:0] d, input logic m, input int lat,
                        input logic [127:0] exp, input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_rdy"}, 128'(ir[k]), 128'd1);
        iv[k] = 1'b1; di[k] = d; mi[k] = m;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        n = 0;
        while (!ov[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(lat));
        chk(tag, dout[k], exp);
    endtask

    task automatic drain(input int k, input string tag);
        @(negedge clk);
        orr[k] = 1'b1;
        @(posedge clk); #1;
        orr[k] = 1'b0;
        chk({tag, "_drain"}, 128'(ov[k]), 128'd0);
    endtask

    initial begin
        logic [127:0] exp_fwd_seq, exp_rt, exp_b;
        int n, bad;
        rst_n = 1'b0; iv = '0; mi = '0; orr = '0;
        for (int k = 0; k < 3; k++) di[k] = '0;
        exp_fwd_seq = 128'h76abd7fe2b670130c56f6bf27b777c63;

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 128'(ir[k]), 128'd1);
            chk("rst_out_valid", 128'(ov[k]), 128'd0);
            chk("rst_data_out", dout[k], 128'd0);
        end

        xact(0, 128'h0, 1'b0, 1, {16{8'h63}}, "l16_zero");
        drain(0, "l16_zero");

`ifdef SUB_BYTES_INV_EN
        xact(0, 128'h0, 1'b1, 1, {16{8'h52}}, "l16_inv_zero");
`else
        xact(0, 128'h0, 1'b1, 1, {16{8'h63}}, "l16_inv_ignored");
`endif
        drain(0, "l16_inv");

        exp_rt = {{15{8'h63}}, 8'hed};
        xact(0, 128'h53, 1'b0, 1, exp_rt, "l16_rt_fwd");
        drain(0, "l16_rt_fwd");
`ifdef SUB_BYTES_INV_EN
        xact(0, exp_rt, 1'b1, 1, 128'h53, "l16_rt_inv");
`else
        xact(0, exp_rt, 1'b1, 1, {{15{8'hfb}}, 8'h55}, "l16_rt_fwdonly");
`endif
        drain(0, "l16_rt_inv");

        // LANES=4 ascending bytes, then hold in DONE under backpressure
        xact(1, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 4, exp_fwd_seq, "l4_seq");
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ov[1] !== 1'b1 || dout[1] !== exp_fwd_seq || ir[1] !== 1'b0) bad++;
        end
        chk("bp_hold", 128'(bad), 128'd0);
        @(negedge clk);
        orr[1] = 1'b1; iv[1] = 1'b1; di[1] = 128'h0; mi[1] = 1'b0;
        #1 chk("bp_b2b_ready", 128'(ir[1]), 128'd1);
        @(posedge clk); #1;
        orr[1] = 1'b0; iv[1] = 1'b0;
        chk("bp_b2b_ovlow", 128'(ov[1]), 128'd0);
        n = 0;
        while (!ov[1] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_b2b_lat", 128'(n), 128'd4);
        chk("bp_b2b_data", dout[1], {16{8'h63}});

`ifdef SUB_BYTES_INV_EN
        exp_b = 128'h0;
`else
        exp_b = {16{8'hfb}};
`endif
        xact(2, {16{8'h63}}, 1'b1, 16, exp_b, "l1_inv");
        drain(2, "l1_inv");

        // Reset while LANES=1 is mid-BUSY and LANES=4 still holds a result in DONE
        @(negedge clk);
        iv[2] = 1'b1; di[2] = 128'h0123456789abcdef0123456789abcdef;
        @(posedge clk); #1 iv[2] = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ov_busy", 128'(ov[2]), 128'd0);
        chk("arst_rdy_busy", 128'(ir[2]), 128'd1);
        chk("arst_data_busy", dout[2], 128'd0);
        chk("arst_ov_done", 128'(ov[1]), 128'd0);
        chk("arst_data_done", dout[1], 128'd0);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov[1] || ov[2]) bad++;
        end
        chk("arst_no_output", 128'(bad), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
